flexbex_ibex_prefetch_ctrl: RTL
===============================

# flexbex_ibex_prefetch_ctrl

Instruction-memory request controller sitting directly upstream of the flexbex ibex fetch FIFO. It issues word-aligned, single-outstanding requests on the instruction bus and forwards each returned word with its fetch address into the FIFO's input port. Branch handling covers flushing the FIFO, redirecting the request address and discarding in-flight stale responses. Sequential prefetch is throttled by the FIFO's ready signal.

## Interface
- No parameters; data/address width fixed at 32.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_i  in  1  core enables sequential prefetching.
- branch_i  in  1  redirect fetch to addr_i this cycle.
- addr_i  in  32  branch target; bit0 ignored (treated 0).
- busy_o  out  1  state != IDLE.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  request address, bits[1:0] always 2'b00.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response data valid.
- instr_rdata_i  in  32  response data.
- fifo_clear_o  out  1  to FIFO clear_i; equals branch_i.
- fifo_valid_o  out  1  to FIFO in_valid_i.
- fifo_addr_o  out  32  to FIFO in_addr_i; fetch address incl. bit1 of a branch target.
- fifo_rdata_o  out  32  to FIFO in_rdata_i; equals instr_rdata_i.
- fifo_ready_i  in  1  from FIFO in_ready_o.

## Operation
- Registers: state (IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED), addr_q[31:0] (address of current/pending request), addr_valid_q (a fetch address exists since reset).
- next_addr = {addr_q[31:2] + 30'd1, 2'b00}; 30-bit wrap from 0xFFFFFFFC to 0x00000000, no flag.
- seq_ok = req_i & fifo_ready_i & addr_valid_q & ~branch_i.
- branch_i always wins; on branch addr_q <= {addr_i[31:1],1'b0}, addr_valid_q <= 1.
- IDLE: branch_i -> instr_req_o=1, instr_addr_o={addr_i[31:2],00}; gnt -> WAIT_RVALID else WAIT_GNT. Else seq_ok -> request next_addr, addr_q <= next_addr; gnt -> WAIT_RVALID else WAIT_GNT. Else stay, instr_req_o=0.
- WAIT_GNT: instr_req_o=1, instr_addr_o={addr_q[31:2],00}, held stable. branch_i redirects same cycle to addr_i (address change permitted only on branch). gnt -> WAIT_RVALID.
- WAIT_RVALID: instr_req_o=0 unless rvalid. On rvalid without branch: fifo_valid_o=1, fifo_addr_o=addr_q; if seq_ok request next_addr same cycle (gnt -> WAIT_RVALID, else WAIT_GNT), else -> IDLE. On rvalid with branch: data dropped (fifo_valid_o=0), branch request issued same cycle as in IDLE. Branch without rvalid: no request, -> WAIT_ABORTED.
- WAIT_ABORTED: instr_req_o=0; further branch_i only updates addr_q. On rvalid: data dropped, request {addr_q[31:2],00} issued same cycle (or branch target if branch_i); gnt -> WAIT_RVALID else WAIT_GNT.
- At most one request outstanding. fifo_valid_o never depends on fifo_ready_i: issue-time check guarantees a free FIFO slot at response time.
- fifo_valid_o=0 in every state except WAIT_RVALID with rvalid and ~branch_i.
- fifo_clear_o = branch_i in every state.

## Timing
- Reset (rst_n=0 at clk edge): state=IDLE, addr_q=0, addr_valid_q=0; hence instr_req_o=0 (unless branch_i), busy_o=0, fifo_valid_o=0, instr_addr_o=0.
- First fetch after reset only via branch_i (boot address delivered as branch).
- Combinational: branch_i/addr_i -> instr_req_o/instr_addr_o/fifo_clear_o; instr_rvalid_i -> fifo_valid_o/fifo_rdata_o; instr_gnt_i -> next state only.
- Zero added latency rvalid -> FIFO push; back-to-back fetch: new request in same cycle as previous rvalid.
- gnt and rvalid never same request same cycle; memory returns rvalid >=1 cycle after gnt.
- Reset mid-transaction: outstanding response after reset arrives in IDLE and is ignored.

## Test plan
- Reset, branch_i addr_i=0x80 with gnt same cycle, rvalid next cycle rdata=0x00000013 -> instr_addr_o=0x80, fifo_valid_o=1, fifo_addr_o=0x80.
- req_i=1, fifo_ready_i=1, gnt/rvalid every cycle from 0x100 -> requests 0x104, 0x108, 0x10C issued same cycle as preceding rvalid.
- Branch to 0x202 -> instr_addr_o=0x200, fifo_addr_o=0x202, fifo_clear_o high one cycle.
- Branch to 0x300 while in WAIT_RVALID, rvalid 3 cycles later -> no req for 3 cycles, stale word not pushed, request 0x300 in rvalid cycle.
- gnt held low 4 cycles -> instr_req_o=1, instr_addr_o stable; fifo_ready_i=0 at rvalid -> push occurs, then IDLE, no new request until ready.
- addr_q=0xFFFFFFFC, sequential fetch -> instr_addr_o=0x00000000.

Source files
------------

// File: rtl/flexbex_ibex_prefetch_ctrl.sv
// flexbex_ibex_prefetch_ctrl
// Single-outstanding instruction-memory request controller feeding the
// fetch FIFO. It handles branch redirects, including discarding a response
// that is already in flight, and throttles sequential prefetch using the
// FIFO's ready signal.
module flexbex_ibex_prefetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,

    // Core side
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,

    // Instruction bus
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,

    // Fetch FIFO input port
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    input  logic        fifo_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_GNT     = 2'd1,
        S_WAIT_RVALID  = 2'd2,
        S_WAIT_ABORTED = 2'd3
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_addr;          // address of the current or pending request
    logic [31:0] w_addr_d;
    logic        r_addr_valid;    // a fetch address has been set since reset
    logic        w_addr_valid_d;

    logic [31:0] w_next_addr;     // next sequential word address
    logic [31:0] w_branch_addr;   // branch target, keeping bit 1 for the FIFO
    logic [31:0] w_branch_word;   // branch target aligned to a bus word
    logic        w_seq_ok;        // a sequential fetch may be issued now
    logic        w_unused_addr_lsb;

    // Derive the candidate request addresses and the sequential-fetch permission.
    always_comb begin
        w_next_addr   = {r_addr[31:2] + 30'd1, 2'b00};
        w_branch_addr = {addr_i[31:1], 1'b0};
        w_branch_word = {addr_i[31:2], 2'b00};
        // A FIFO slot is checked when the request is issued. The response
        // can then be pushed without checking fifo_ready_i again.
        w_seq_ok      = req_i & fifo_ready_i & r_addr_valid & ~branch_i;
    end

    // Instruction addresses are halfword aligned, so bit 0 of the target carries no information.
    assign w_unused_addr_lsb = addr_i[0];

    // Next-state, next-address and bus/FIFO output decode.
    always_comb begin
        // NOTE: every signal this block drives gets a default first. Then each
        // path through the case assigns it, and no latch can be inferred.
        w_state_d      = r_state;
        w_addr_d       = r_addr;
        w_addr_valid_d = r_addr_valid;
        instr_req_o    = 1'b0;
        instr_addr_o   = {r_addr[31:2], 2'b00};
        fifo_valid_o   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (branch_i) begin
                    instr_req_o    = 1'b1;
                    instr_addr_o   = w_branch_word;
                    w_addr_d       = w_branch_addr;
                    w_addr_valid_d = 1'b1;
                    w_state_d      = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                end else if (w_seq_ok) begin
                    instr_req_o    = 1'b1;
                    instr_addr_o   = w_next_addr;
                    w_addr_d       = w_next_addr;
                    w_state_d      = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                end
            end

            S_WAIT_GNT: begin
                // The request stays asserted. Its address changes only when a branch redirects it.
                instr_req_o = 1'b1;
                if (branch_i) begin
                    instr_addr_o   = w_branch_word;
                    w_addr_d       = w_branch_addr;
                    w_addr_valid_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    w_state_d = S_WAIT_RVALID;
                end
            end

            S_WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    if (branch_i) begin
                        // The returning word is stale: drop it and start the branch fetch.
                        instr_req_o    = 1'b1;
                        instr_addr_o   = w_branch_word;
                        w_addr_d       = w_branch_addr;
                        w_addr_valid_d = 1'b1;
                        w_state_d      = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                    end else begin
                        fifo_valid_o = 1'b1;
                        if (w_seq_ok) begin
                            instr_req_o  = 1'b1;
                            instr_addr_o = w_next_addr;
                            w_addr_d     = w_next_addr;
                            w_state_d    = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end
                end else if (branch_i) begin
                    // Only one request may be outstanding. Record the target
                    // now and issue it once the stale response has drained.
                    w_addr_d       = w_branch_addr;
                    w_addr_valid_d = 1'b1;
                    w_state_d      = S_WAIT_ABORTED;
                end
            end

            S_WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    instr_req_o = 1'b1;
                    if (branch_i) begin
                        instr_addr_o   = w_branch_word;
                        w_addr_d       = w_branch_addr;
                        w_addr_valid_d = 1'b1;
                    end
                    w_state_d = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                end else if (branch_i) begin
                    w_addr_d       = w_branch_addr;
                    w_addr_valid_d = 1'b1;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and fetch-address registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples its value from before the clock edge, whatever the
        // statement order.
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'h0000_0000;
            r_addr_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_addr       <= w_addr_d;
            r_addr_valid <= w_addr_valid_d;
        end
    end

    // Pass-through and status outputs.
    always_comb begin
        busy_o       = (r_state != S_IDLE);
        fifo_clear_o = branch_i;
        fifo_addr_o  = r_addr;
        fifo_rdata_o = instr_rdata_i;
    end

endmodule
